nv_sync_evt_arb: RTL and testbench

NV_SYNC_EVT_ARB -- requirements
Module: nv_sync_evt_arb

---
 rtl/nv_sync_evt_arb.sv | 134 +++++++++++++
 tb/tb_nv_sync_evt_arb.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nv_sync_evt_arb.sv
// Round-robin event arbiter that hands one transfer at a time to a far clock
// domain over a toggle/ack handshake, with a timeout watchdog on the ack.
module nv_sync_evt_arb #(
  parameter  int NUM_REQ = 4,
  parameter  int TIMEOUT = 255,
  localparam int IDW     = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] evt_req,
  output logic [NUM_REQ-1:0] evt_gnt,
  output logic [NUM_REQ-1:0] evt_done,
  output logic [IDW-1:0]     xfer_id,
  output logic               xfer_tgl,
  input  logic               xfer_ack_async,
  output logic               busy,
  output logic               timeout_err,
  input  logic               err_clr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t state, state_d;

  (* preserve *) logic ack_s1;
  (* preserve *) logic ack_s2;
  (* preserve *) logic ack_s3;

  logic [15:0]        cnt, cnt_d;
  logic [IDW-1:0]     ptr, ptr_d;
  logic [IDW-1:0]     win, ptr_next, idx;
  logic [IDW-1:0]     id_d;
  logic [NUM_REQ-1:0] gnt_d, done_d;
  logic               tgl_d, err_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value; blocking here would let ack_s1 ripple straight to ack_s3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
      ack_s3 <= 1'b0;
    end else begin
      ack_s1 <= xfer_ack_async;
      ack_s2 <= ack_s1;
      ack_s3 <= ack_s2;
    end
  end

  // Round-robin search starting at ptr; first requester found wins.
  always_comb begin
    win = ptr;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = IDW'((int'(ptr) + i) % NUM_REQ);
      if (evt_req[idx]) win = idx;
    end
    ptr_next = IDW'((int'(win) + 1) % NUM_REQ);
  end

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state;
    gnt_d   = '0;
    done_d  = '0;
    tgl_d   = xfer_tgl;
    id_d    = xfer_id;
    cnt_d   = cnt;
    ptr_d   = ptr;
    err_d   = timeout_err;
    case (state)
      S_IDLE: begin
        if (|evt_req) begin
          gnt_d   = NUM_REQ'(1) << win;
          tgl_d   = ~xfer_tgl;
          id_d    = win;
          cnt_d   = '0;
          ptr_d   = ptr_next;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A match wins over an expiring counter in the same cycle.
        if (ack_s3 == xfer_tgl) begin
          done_d  = NUM_REQ'(1) << xfer_id;
          state_d = S_IDLE;
        end else if (cnt == 16'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_ERR: begin
        if (err_clr) begin
          err_d   = 1'b0;
          tgl_d   = ack_s3;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      evt_gnt     <= '0;
      evt_done    <= '0;
      xfer_tgl    <= 1'b0;
      xfer_id     <= '0;
      cnt         <= '0;
      ptr         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      evt_gnt     <= gnt_d;
      evt_done    <= done_d;
      xfer_tgl    <= tgl_d;
      xfer_id     <= id_d;
      cnt         <= cnt_d;
      ptr         <= ptr_d;
      timeout_err <= err_d;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_nv_sync_evt_arb.sv
// Scoreboard bench for nv_sync_evt_arb: expected grants are queued by the
// stimulus, expected completions are derived from each observed grant.
module tb_nv_sync_evt_arb;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 8;
  localparam int IDW     = 2;

  typedef struct {
    int idx;
    int cyc;
  } done_exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_REQ-1:0] evt_req;
  logic [NUM_REQ-1:0] evt_gnt;
  logic [NUM_REQ-1:0] evt_done;
  logic [IDW-1:0]     xfer_id;
  logic               xfer_tgl;
  logic               xfer_ack_async;
  logic               busy;
  logic               timeout_err;
  logic               err_clr;

  logic loop_mode;
  logic ack_force;
  assign xfer_ack_async = loop_mode ? xfer_tgl : ack_force;

  nv_sync_evt_arb #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .evt_req       (evt_req),
    .evt_gnt       (evt_gnt),
    .evt_done      (evt_done),
    .xfer_id       (xfer_id),
    .xfer_tgl      (xfer_tgl),
    .xfer_ack_async(xfer_ack_async),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .err_clr       (err_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int gnt_count = 0;
  int last_gnt_cyc = 0;
  int done_lat = 0;
  int gnt_q[$];
  done_exp_t done_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops expected grants/completions as the DUT produces them.
  always @(negedge clk) begin
    if (evt_gnt != '0 || evt_done != '0)
      check("gnt_done_excl", 32'((evt_gnt != '0) && (evt_done != '0)), 32'd0);
    if (evt_gnt != '0) begin
      gnt_count++;
      last_gnt_cyc = cyc;
      if (gnt_q.size() == 0) begin
        check("gnt_unexpected", 32'(evt_gnt), 32'd0);
      end else begin
        int e;
        e = gnt_q.pop_front();
        check("gnt", 32'(evt_gnt), 32'(1 << e));
        check("xfer_id", 32'(xfer_id), 32'(e));
        if (done_lat != 0) done_q.push_back('{idx: e, cyc: cyc + done_lat});
      end
    end
    if (evt_done != '0) begin
      if (done_q.size() == 0) begin
        check("done_unexpected", 32'(evt_done), 32'd0);
      end else begin
        done_exp_t d;
        d = done_q.pop_front();
        check("done", 32'(evt_done), 32'(1 << d.idx));
        check("done_cycle", 32'(cyc), 32'(d.cyc));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_gnt();
    int start;
    start = gnt_count;
    for (int k = 0; k < 40 && gnt_count == start; k++) step();
    if (gnt_count == start) check("gnt_wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_gnt"},  32'(evt_gnt),     32'd0);
    check({tag, "_done"}, 32'(evt_done),    32'd0);
    check({tag, "_id"},   32'(xfer_id),     32'd0);
    check({tag, "_tgl"},  32'(xfer_tgl),    32'd0);
    check({tag, "_busy"}, 32'(busy),        32'd0);
    check({tag, "_err"},  32'(timeout_err), 32'd0);
  endtask

  logic tgl_m;
  int   prev_gnt;
  int   rel_cyc;

  initial begin
    rst = 1'b1; evt_req = '0; err_clr = 1'b0; loop_mode = 1'b1; ack_force = 1'b0;
    tgl_m = 1'b0;
    step(); step();
    check_cleared("reset");
    rst = 1'b0;
    step();

    // Single requester, loopback: 4-cycle latency, busy for 4 cycles.
    done_lat = 4;
    gnt_q.push_back(0);
    evt_req = 4'b0001;
    wait_gnt();
    tgl_m = ~tgl_m;
    check("t1_tgl", 32'(xfer_tgl), 32'(tgl_m));
    check("t1_busy_e", 32'(busy), 32'd1);
    evt_req = '0;
    for (int k = 1; k <= 3; k++) begin
      step();
      check("t1_busy", 32'(busy), 32'd1);
    end
    step();
    check("t1_idle", 32'(busy), 32'd0);
    step(); step();

    // All four requesting after reset: 0,1,2,3,0 every 5 cycles.
    rst = 1'b1;
    step(); step();
    tgl_m = 1'b0;
    foreach (gnt_q[i]) gnt_q.delete(i);
    for (int i = 0; i < 5; i++) gnt_q.push_back(i % NUM_REQ);
    evt_req = 4'b1111;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_gnt();
      tgl_m = ~tgl_m;
      check("t2_tgl", 32'(xfer_tgl), 32'(tgl_m));
      if (i > 0) check("t2_gap", 32'(last_gnt_cyc - prev_gnt), 32'd5);
      prev_gnt = last_gnt_cyc;
    end
    evt_req = '0;
    repeat (6) step();

    // Ack frozen: timeout into ERR, then err_clr realigns the channel.
    ack_force = tgl_m;
    loop_mode = 1'b0;
    done_lat = 0;
    gnt_q.push_back(1);
    evt_req = 4'b0010;
    wait_gnt();
    tgl_m = ~tgl_m;
    evt_req = '0;
    for (int k = 0; k < 20 && !timeout_err; k++) step();
    check("t3_err_set", 32'(timeout_err), 32'd1);
    check("t3_err_lat", 32'(cyc - last_gnt_cyc), 32'd9);
    step(); step();
    check("t3_err_hold", 32'(timeout_err), 32'd1);
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_id_hold", 32'(xfer_id), 32'd1);
    check("t3_tgl_hold", 32'(xfer_tgl), 32'(tgl_m));
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    tgl_m = ack_force;
    check("t3_err_clr", 32'(timeout_err), 32'd0);
    check("t3_busy_clr", 32'(busy), 32'd0);
    check("t3_realign", 32'(xfer_tgl), 32'(tgl_m));
    step();

    // Match lands exactly on count == TIMEOUT: completion, no error.
    done_lat = 9;
    gnt_q.push_back(2);
    evt_req = 4'b0100;
    wait_gnt();
    tgl_m = ~tgl_m;
    evt_req = '0;
    repeat (5) step();
    ack_force = tgl_m;
    repeat (5) step();
    check("t4_no_err", 32'(timeout_err), 32'd0);
    check("t4_idle", 32'(busy), 32'd0);

    // Reset mid-WAIT abandons the transfer; first edge after release arbitrates.
    loop_mode = 1'b1;
    done_lat = 0;
    gnt_q.push_back(0);
    evt_req = 4'b0001;
    wait_gnt();
    evt_req = '0;
    step();
    rst = 1'b1;
    #1;
    check_cleared("t5_rst");
    tgl_m = 1'b0;
    step(); step();
    done_lat = 4;
    gnt_q.push_back(0);
    evt_req = 4'b1001;
    rst = 1'b0;
    rel_cyc = cyc;
    wait_gnt();
    tgl_m = ~tgl_m;
    check("t5_first_edge", 32'(last_gnt_cyc), 32'(rel_cyc + 1));
    check("t5_tgl", 32'(xfer_tgl), 32'(tgl_m));
    evt_req = '0;
    repeat (5) step();

    // Short pulse on requester 2 during WAIT must never be granted.
    gnt_q.push_back(1);
    evt_req = 4'b0010;
    wait_gnt();
    evt_req = 4'b0100;
    step();
    evt_req = '0;
    repeat (10) step();

    check("gnt_q_empty", 32'(gnt_q.size()), 32'd0);
    check("done_q_empty", 32'(done_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
